// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction-fetch front end.
// It issues one word-aligned inst SRAM read per cycle while there is room.
// Responses come back one cycle later and are buffered in a DEPTH-entry queue of {pc, inst}.
// Decode pops from the head. A redirect flushes the queue and drops any response arriving in that cycle.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode
// when the queue is empty. This saves one cycle of fetch-to-decode latency.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   redirect_valid_i,
   input  logic [31:0]            redirect_pc_i,
   output logic                   inst_sram_en,
   output logic [3:0]             inst_sram_we,
   output logic [31:0]            inst_sram_addr,
   output logic [31:0]            inst_sram_wdata,
   input  logic [31:0]            inst_sram_rdata,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [31:0]            out_pc_o,
   output logic [31:0]            out_inst_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fq_entry_t;

   // fetch state
   logic [31:0]   pc_q;
   logic          started;
   logic          inflight_v;
   logic          inflight_kill;
   logic [31:0]   inflight_pc;

   // queue state
   fq_entry_t     mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   // per-cycle control
   fq_entry_t     head;
   logic          fifo_empty;
   logic          resp_live;
   logic          bypass;
   logic          pop;
   logic          fifo_pop;
   logic          push;
   logic [CW:0]   occ;
   logic          credit;
   logic          issue;

   // The low two bits of the redirect target are discarded: fetch is word aligned.
   logic          unused_pc_lsb;
   assign unused_pc_lsb = ^redirect_pc_i[1:0];

   assign fifo_empty = (count == '0);
   // A response is usable unless it was marked stale or decode is redirecting right now.
   assign resp_live  = inflight_v & ~inflight_kill & ~redirect_valid_i;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = fifo_empty & resp_live;
`else
   assign bypass = 1'b0;
`endif

   // Head presentation: queue head, or the live response when bypassing an empty queue.
   always_comb begin
      head        = mem[rd_ptr];
      out_valid_o = ~fifo_empty;
      out_pc_o    = head.pc;
      out_inst_o  = head.inst;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (bypass) begin
         out_valid_o = 1'b1;
         out_pc_o    = inflight_pc;
         out_inst_o  = inst_sram_rdata;
      end
`endif
   end

   assign pop      = out_valid_o & out_ready_i;
   // A pop in a redirect cycle is ignored; the flush wins.
   assign fifo_pop = pop & ~fifo_empty & ~redirect_valid_i;
   // A bypassed response that decode takes this cycle never enters the queue.
   assign push     = resp_live & ~(bypass & pop);

   // Reserve a slot for the outstanding response so the queue can never overflow.
   // Counting this cycle's pop lets fetch resume in the same cycle ready rises.
   assign occ    = {1'b0, count} + (CW+1)'(inflight_v) - (CW+1)'(pop);
   assign credit = occ < (CW+1)'(DEPTH);
   assign issue  = started & credit & ~redirect_valid_i;

   assign inst_sram_en    = issue;
   assign inst_sram_addr  = pc_q;
   assign inst_sram_we    = 4'b0;
   assign inst_sram_wdata = 32'b0;
   assign count_o         = count;

   // Fetch PC, outstanding-request tracking, and queue pointers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q          <= RESET_PC;
         started       <= 1'b0;
         inflight_v    <= 1'b0;
         inflight_kill <= 1'b0;
         inflight_pc   <= '0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
      end else begin
         started <= 1'b1;
         if (redirect_valid_i) begin
            pc_q          <= {redirect_pc_i[31:2], 2'b00};
            inflight_v    <= 1'b0;
            inflight_kill <= 1'b1;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
         end else begin
            if (issue) begin
               pc_q          <= pc_q + 32'd4;
               inflight_v    <= 1'b1;
               inflight_pc   <= pc_q;
               inflight_kill <= 1'b0;
            end else begin
               inflight_v    <= 1'b0;
            end
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(fifo_pop);
         end
      end
   end

   // Queue storage. It has no reset because entries are only read once count marks them valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{pc: inflight_pc, inst: inst_sram_rdata};
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue-based reference model is checked every cycle.
// Directed scenarios carry literal expectations.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int VLAT = 1;
   localparam bit BYP  = 1'b1;
`else
   localparam int VLAT = 2;
   localparam bit BYP  = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata = 32'hDEAD_BEEF;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_pc_o;
   logic [31:0] out_inst_o;
   logic [2:0]  count_o;
   logic [31:0] xk;

   int checks = 0;
   int errors = 0;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .resetn(resetn),
      .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
      .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
      .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   // SRAM: one-cycle read latency; data is the address xor a pattern key.
   always @(posedge clk)
      inst_sram_rdata <= inst_sram_en ? (inst_sram_addr ^ xk) : 32'hDEAD_BEEF;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_pc      = RESET_PC;
   bit          m_started = 0;
   bit          m_inf_v   = 0;
   logic [31:0] m_inf_pc  = '0;
   bit          m_byp, m_valid, m_pop, m_en;
   logic [31:0] m_hpc, m_hinst;
   int          m_occ;

   // Compare the outputs mid-cycle, then advance the model across the next edge.
   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_en", 32'(inst_sram_en), 0);
         chk("rst_valid", 32'(out_valid_o), 0);
         chk("rst_count", 32'(count_o), 0);
         m_q.delete();
         m_pc = RESET_PC; m_started = 0; m_inf_v = 0;
      end else begin
         m_byp   = BYP && m_q.size() == 0 && m_inf_v && !redirect_valid_i;
         m_valid = m_q.size() > 0 || m_byp;
         m_hpc   = m_q.size() > 0 ? m_q[0].pc   : m_inf_pc;
         m_hinst = m_q.size() > 0 ? m_q[0].inst : inst_sram_rdata;
         m_pop   = m_valid && out_ready_i;
         m_occ   = m_q.size() + int'(m_inf_v) - int'(m_pop);
         m_en    = m_started && m_occ < DEPTH && !redirect_valid_i;
         chk("en", 32'(inst_sram_en), 32'(m_en));
         if (m_en) chk("addr", inst_sram_addr, m_pc);
         chk("valid", 32'(out_valid_o), 32'(m_valid));
         if (m_valid) begin
            chk("head_pc", out_pc_o, m_hpc);
            chk("head_inst", out_inst_o, m_hinst);
         end
         chk("count", 32'(count_o), 32'(m_q.size()));
         chk("we", 32'(inst_sram_we), 0);
         chk("wdata", inst_sram_wdata, 0);
         if (redirect_valid_i) begin
            m_q.delete();
            m_pc    = redirect_pc_i & 32'hFFFF_FFFC;
            m_inf_v = 0;
         end else begin
            if (m_pop && m_q.size() > 0) void'(m_q.pop_front());
            if (m_inf_v && !(m_byp && m_pop)) m_q.push_back('{m_inf_pc, inst_sram_rdata});
            m_inf_v = m_en;
            if (m_en) begin
               m_inf_pc = m_pc;
               m_pc     = m_pc + 32'd4;
            end
         end
         m_started = 1;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(); @(posedge clk); #1; endtask
   task automatic mid();  @(negedge clk); #1; endtask

   // Call from within the cycle that requested pc: confirms the valid latency and the head.
   task automatic expect_target(input string nm, input logic [31:0] pc);
      repeat (VLAT - 1) begin
         step(); mid();
         chk({nm, "_lat"}, 32'(out_valid_o), 0);
      end
      step(); mid();
      chk({nm, "_valid"}, 32'(out_valid_o), 1);
      chk({nm, "_pc"}, out_pc_o, pc);
      chk({nm, "_inst"}, out_inst_o, pc ^ xk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      resetn = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
      out_ready_i = 1'b1; xk = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("lit_rst_en", 32'(inst_sram_en), 0);
      chk("lit_rst_count", 32'(count_o), 0);

      // Reset release: first request in the second cycle, then streaming.
      resetn = 1'b1;
      mid(); chk("lit_cycle1_en", 32'(inst_sram_en), 0);
      step(); mid();
      chk("lit_first_en", 32'(inst_sram_en), 1);
      chk("lit_first_addr", inst_sram_addr, RESET_PC);
      expect_target("lit_first", RESET_PC);
      repeat (8) step();
      xk = 32'h0F0F_0000;

      // Stall from empty: exactly DEPTH requests, then drain in order.
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_2000; out_ready_i = 1'b0;
      step(); redirect_valid_i = 1'b0;
      n = 0;
      repeat (10) begin
         mid();
         if (inst_sram_en) n++;
         step();
      end
      mid();
      chk("lit_fill_reqs", 32'(n), 4);
      chk("lit_fill_count", 32'(count_o), 4);
      chk("lit_fill_en", 32'(inst_sram_en), 0);
      step(); out_ready_i = 1'b1;
      mid();
      chk("lit_resume_en", 32'(inst_sram_en), 1);
      chk("lit_drain0", out_pc_o, 32'h0000_2000);
      for (int i = 1; i < 4; i++) begin
         step(); mid();
         chk("lit_drain", out_pc_o, 32'h0000_2000 + 32'(4 * i));
      end

      // Redirect with three queued entries and one response in flight.
      step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_3000; out_ready_i = 1'b0;
      step(); redirect_valid_i = 1'b0;
      repeat (4) step();
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_1002;
      mid(); chk("lit_pre_redir_count", 32'(count_o), 3);
      step(); redirect_valid_i = 1'b0; out_ready_i = 1'b1;
      mid();
      chk("lit_flush_count", 32'(count_o), 0);
      chk("lit_redir_en", 32'(inst_sram_en), 1);
      chk("lit_redir_addr", inst_sram_addr, 32'h0000_1000);
      expect_target("lit_redir", 32'h0000_1000);

      // Redirect in the same cycle as a pop.
      step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_4000;
      mid(); chk("lit_pop_redir_valid", 32'(out_valid_o), 1);
      step(); redirect_valid_i = 1'b0;
      mid(); chk("lit_post_redir_valid", 32'(out_valid_o), 0);
      expect_target("lit_pop_redir", 32'h0000_4000);

      // PC wrap past the top of the address space.
      step(); redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
      step(); redirect_valid_i = 1'b0;
      mid(); chk("lit_wrap0", inst_sram_addr, 32'hFFFF_FFF8);
      step(); mid(); chk("lit_wrap1", inst_sram_addr, 32'hFFFF_FFFC);
      step(); mid(); chk("lit_wrap2", inst_sram_addr, 32'h0000_0000);
      repeat (4) step();

      // Reset mid-operation with two entries queued and one in flight.
      redirect_valid_i = 1'b1; redirect_pc_i = 32'h0000_5000; out_ready_i = 1'b0;
      step(); redirect_valid_i = 1'b0;
      repeat (3) step();
      chk("lit_pre_rst_count", 32'(count_o), 2);
      resetn = 1'b0;
      #1;
      chk("lit_async_en", 32'(inst_sram_en), 0);
      chk("lit_async_valid", 32'(out_valid_o), 0);
      chk("lit_async_count", 32'(count_o), 0);
      out_ready_i = 1'b1;
      step(); step();
      resetn = 1'b1;
      mid(); chk("lit_rel_cycle1_en", 32'(inst_sram_en), 0);
      step(); mid();
      chk("lit_rel_addr", inst_sram_addr, RESET_PC);
      expect_target("lit_restart", RESET_PC);
      repeat (6) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
